// File: rtl/dev_rsp_pkg.sv
// Shared types and constants for the device response serializer.
package dev_rsp_pkg;

    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 16;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    // Transactions carrying this ID are parked while the device is not operational.
    localparam logic [2:0] DEFER_TID = 3'h5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // One device transaction as stored in the defer FIFO and the output holding registers.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dev_txn_t;

endpackage

// File: rtl/qs_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on dout while not empty.
module qs_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dev_rsp_serializer.sv
// Serializes device transactions into an address beat plus a data beat on a stream,
// parking DEFER_TID traffic in a FIFO until the device becomes operational.
module dev_rsp_serializer
    import dev_rsp_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dev_valid_i,
    input  logic [ADDR_W-1:0]        dev_addr_i,
    input  logic [DATA_W-1:0]        dev_data_i,
    output logic                     dev_ready_o,
    input  logic                     dev_opmode_i,
    output logic                     rsp_tvalid_o,
    output logic [2:0]               rsp_tid_o,
    output logic [15:0]              rsp_tdata_o,
    output logic                     rsp_tlast_o,
    input  logic                     rsp_tready_i,
    output logic [$clog2(DEPTH):0]   defer_cnt_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t            cs;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    dev_txn_t          fifo_head;
    dev_txn_t          dev_txn;
    dev_txn_t          ld_txn;
    logic              fifo_empty;
    logic              fifo_full;
    logic              defer;
    logic              drain;
    logic              push_en;
    logic              direct_acc;
    logic              load;

    assign dev_txn = '{addr: dev_addr_i, data: dev_data_i};

    // Defer and drain need opposite opmode, so push and pop never coincide.
    assign defer      = dev_valid_i && (dev_addr_i[2:0] == DEFER_TID) && !dev_opmode_i;
    assign drain      = (cs == IDLE) && !fifo_empty && dev_opmode_i;
    // Ready looks at valid/addr; upstream valid must not look at ready.
    assign dev_ready_o = defer ? !fifo_full : ((cs == IDLE) && !drain);
    assign push_en    = defer && !fifo_full;
    assign direct_acc = dev_valid_i && dev_ready_o && !defer;
    assign load       = drain || direct_acc;
    assign ld_txn     = drain ? fifo_head : dev_txn;

    qs_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_defer_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_en),
        .din   (dev_txn),
        .pop   (drain),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Occupancy tracker; cannot exceed DEPTH because pushes stop at full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            defer_cnt_o <= '0;
        end else if (push_en) begin
            defer_cnt_o <= defer_cnt_o + CW'(1);
        end else if (drain) begin
            defer_cnt_o <= defer_cnt_o - CW'(1);
        end
    end

    // Two-beat output FSM; stream outputs are registered so they hold under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs           <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            rsp_tvalid_o <= 1'b0;
            rsp_tid_o    <= '0;
            rsp_tdata_o  <= '0;
            rsp_tlast_o  <= 1'b0;
        end else begin
            case (cs)
                IDLE: begin
                    if (load) begin
                        addr_q       <= ld_txn.addr;
                        data_q       <= ld_txn.data;
                        rsp_tvalid_o <= 1'b1;
                        rsp_tdata_o  <= ld_txn.addr[ADDR_W-1:3];
                        rsp_tid_o    <= ld_txn.addr[2:0];
                        rsp_tlast_o  <= 1'b0;
                        cs           <= ADDR;
                    end
                end
                ADDR: begin
                    if (rsp_tready_i) begin
                        rsp_tdata_o <= data_q;
                        rsp_tid_o   <= addr_q[2:0];
                        rsp_tlast_o <= 1'b1;
                        cs          <= DATA;
                    end
                end
                DATA: begin
                    if (rsp_tready_i) begin
                        rsp_tvalid_o <= 1'b0;
                        rsp_tlast_o  <= 1'b0;
                        cs           <= IDLE;
                    end
                end
                default: begin
                    rsp_tvalid_o <= 1'b0;
                    rsp_tlast_o  <= 1'b0;
                    cs           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dev_rsp_serializer.sv
// Scoreboard bench for dev_rsp_serializer: tasks push expected beats, a monitor pops and compares.
module tb_dev_rsp_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        dev_valid;
    logic [18:0] dev_addr;
    logic [15:0] dev_data;
    logic        dev_ready;
    logic        dev_opmode;
    logic        rsp_tvalid;
    logic [2:0]  rsp_tid;
    logic [15:0] rsp_tdata;
    logic        rsp_tlast;
    logic        rsp_tready;
    logic [4:0]  defer_cnt;

    int checks   = 0;
    int failures = 0;

    // Expected beat: {tdata, tid, tlast}
    logic [19:0] exp_q[$];

    dev_rsp_serializer #(.DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .dev_valid_i  (dev_valid),
        .dev_addr_i   (dev_addr),
        .dev_data_i   (dev_data),
        .dev_ready_o  (dev_ready),
        .dev_opmode_i (dev_opmode),
        .rsp_tvalid_o (rsp_tvalid),
        .rsp_tid_o    (rsp_tid),
        .rsp_tdata_o  (rsp_tdata),
        .rsp_tlast_o  (rsp_tlast),
        .rsp_tready_i (rsp_tready),
        .defer_cnt_o  (defer_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every beat that will transfer on the next edge must match the queue head.
    always @(negedge clk) begin
        if (!reset && rsp_tvalid && rsp_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat got tdata=%h tid=%0d tlast=%0b, expected no beat",
                         rsp_tdata, rsp_tid, rsp_tlast);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({rsp_tdata, rsp_tid, rsp_tlast} !== e) begin
                    failures++;
                    $display("FAIL beat got tdata=%h tid=%0d tlast=%0b, expected tdata=%h tid=%0d tlast=%0b",
                             rsp_tdata, rsp_tid, rsp_tlast, e[19:4], e[3:1], e[0]);
                end
            end
        end
    end

    function automatic void expect_txn(input logic [18:0] a, input logic [15:0] d);
        exp_q.push_back({a[18:3], a[2:0], 1'b0});
        exp_q.push_back({d, a[2:0], 1'b1});
    endfunction

    // Present one transaction and hold it until the DUT accepts it; returns at posedge+1.
    task automatic drive_txn(input logic [18:0] a, input logic [15:0] d);
        bit ok;
        ok = 0;
        dev_valid = 1'b1;
        dev_addr  = a;
        dev_data  = d;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dev_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        dev_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout addr=%h never accepted, expected acceptance", a);
        end
    endtask

    // Wait until the scoreboard is empty and the stream idles.
    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_tvalid) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout pending=%0d beats, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dev_valid = 1'b0; dev_addr = '0; dev_data = '0;
        dev_opmode = 1'b1; rsp_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rsp_tvalid, rsp_tlast, rsp_tid, rsp_tdata} !== 21'd0) begin
            failures++;
            $display("FAIL reset_stream got v=%0b l=%0b tid=%0d data=%h, expected all 0",
                     rsp_tvalid, rsp_tlast, rsp_tid, rsp_tdata);
        end
        checks++;
        if (defer_cnt !== 5'd0 || dev_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl got cnt=%0d ready=%0b, expected cnt=0 ready=1", defer_cnt, dev_ready);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_direct();
        dev_opmode = 1'b1; rsp_tready = 1'b1;
        expect_txn(19'h1_2343, 16'hBEEF);
        drive_txn(19'h1_2343, 16'hBEEF);
        checks++;
        if ({rsp_tvalid, rsp_tdata, rsp_tid, rsp_tlast} !== {1'b1, 16'h2468, 3'd3, 1'b0}) begin
            failures++;
            $display("FAIL direct_addr_beat got v=%0b data=%h tid=%0d l=%0b, expected 1/2468/3/0",
                     rsp_tvalid, rsp_tdata, rsp_tid, rsp_tlast);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_tvalid, rsp_tdata, rsp_tid, rsp_tlast} !== {1'b1, 16'hBEEF, 3'd3, 1'b1}) begin
            failures++;
            $display("FAIL direct_data_beat got v=%0b data=%h tid=%0d l=%0b, expected 1/beef/3/1",
                     rsp_tvalid, rsp_tdata, rsp_tid, rsp_tlast);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL direct_idle got tvalid=%0b, expected 0", rsp_tvalid);
        end
    endtask

    task automatic test_backpressure();
        dev_opmode = 1'b1; rsp_tready = 1'b0;
        expect_txn(19'h1_2343, 16'hBEEF);
        drive_txn(19'h1_2343, 16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_tvalid, rsp_tdata, rsp_tid, rsp_tlast, dev_ready} !== {1'b1, 16'h2468, 3'd3, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL bp_addr_hold got v=%0b data=%h tid=%0d l=%0b rdy=%0b, expected 1/2468/3/0/0",
                         rsp_tvalid, rsp_tdata, rsp_tid, rsp_tlast, dev_ready);
            end
            @(posedge clk); #1;
        end
        rsp_tready = 1'b1;
        @(posedge clk); #1;
        rsp_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_tvalid, rsp_tdata, rsp_tid, rsp_tlast, dev_ready} !== {1'b1, 16'hBEEF, 3'd3, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL bp_data_hold got v=%0b data=%h tid=%0d l=%0b rdy=%0b, expected 1/beef/3/1/0",
                         rsp_tvalid, rsp_tdata, rsp_tid, rsp_tlast, dev_ready);
            end
            @(posedge clk); #1;
        end
        rsp_tready = 1'b1;
        wait_idle(20);
    endtask

    task automatic test_defer_drain();
        dev_opmode = 1'b0; rsp_tready = 1'b1;
        for (int i = 1; i <= 3; i++) drive_txn({16'hA000 + 16'(i), 3'h5}, 16'(i));
        checks++;
        if (defer_cnt !== 5'd3) begin
            failures++;
            $display("FAIL defer_cnt got %0d, expected 3", defer_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL defer_quiet got tvalid=%0b, expected 0", rsp_tvalid);
            end
        end
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) expect_txn({16'hA000 + 16'(i), 3'h5}, 16'(i));
        dev_opmode = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rsp_tvalid, rsp_tdata, defer_cnt} !== {1'b1, 16'hA001, 5'd2}) begin
            failures++;
            $display("FAIL drain_latency got v=%0b data=%h cnt=%0d, expected 1/a001/2",
                     rsp_tvalid, rsp_tdata, defer_cnt);
        end
        wait_idle(50);
        checks++;
        if (defer_cnt !== 5'd0) begin
            failures++;
            $display("FAIL drain_cnt got %0d, expected 0", defer_cnt);
        end
    endtask

    task automatic test_full();
        dev_opmode = 1'b0; rsp_tready = 1'b1;
        for (int i = 0; i < 16; i++) drive_txn({16'h0100 + 16'(i), 3'h5}, 16'h0200 + 16'(i));
        dev_valid = 1'b1; dev_addr = {16'h0FFF, 3'h5}; dev_data = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dev_ready !== 1'b0 || defer_cnt !== 5'd16) begin
                failures++;
                $display("FAIL full_block got ready=%0b cnt=%0d, expected ready=0 cnt=16", dev_ready, defer_cnt);
            end
            @(posedge clk); #1;
        end
        dev_valid = 1'b0;
        expect_txn({16'h0777, 3'h2}, 16'h7777);
        drive_txn({16'h0777, 3'h2}, 16'h7777);
        checks++;
        if (rsp_tvalid !== 1'b1 || rsp_tid !== 3'd2) begin
            failures++;
            $display("FAIL full_bypass got v=%0b tid=%0d, expected 1/2", rsp_tvalid, rsp_tid);
        end
        wait_idle(20);
        checks++;
        if (defer_cnt !== 5'd16) begin
            failures++;
            $display("FAIL full_bypass_cnt got %0d, expected 16", defer_cnt);
        end
        for (int i = 0; i < 16; i++) expect_txn({16'h0100 + 16'(i), 3'h5}, 16'h0200 + 16'(i));
        dev_opmode = 1'b1;
        wait_idle(200);
        checks++;
        if (defer_cnt !== 5'd0) begin
            failures++;
            $display("FAIL full_drain_cnt got %0d, expected 0", defer_cnt);
        end
    endtask

    task automatic test_drain_priority();
        dev_opmode = 1'b0; rsp_tready = 1'b1;
        drive_txn({16'h0021, 3'h5}, 16'h0021);
        drive_txn({16'h0022, 3'h5}, 16'h0022);
        expect_txn({16'h0021, 3'h5}, 16'h0021);
        expect_txn({16'h0022, 3'h5}, 16'h0022);
        expect_txn({16'h0031, 3'h1}, 16'h0031);
        dev_opmode = 1'b1;
        dev_valid = 1'b1; dev_addr = {16'h0031, 3'h1}; dev_data = 16'h0031;
        @(negedge clk);
        checks++;
        if (dev_ready !== 1'b0) begin
            failures++;
            $display("FAIL prio_stall got ready=%0b, expected 0", dev_ready);
        end
        @(posedge clk); #1;
        drive_txn({16'h0031, 3'h1}, 16'h0031);
        wait_idle(50);
        checks++;
        if (defer_cnt !== 5'd0) begin
            failures++;
            $display("FAIL prio_cnt got %0d, expected 0", defer_cnt);
        end
    endtask

    task automatic test_reset_mid();
        dev_opmode = 1'b0; rsp_tready = 1'b1;
        for (int i = 0; i < 4; i++) drive_txn({16'h0040 + 16'(i), 3'h5}, 16'h0040 + 16'(i));
        // Only the address beat is expected; the data beat is killed by reset.
        exp_q.push_back({16'h0050, 3'h2, 1'b0});
        drive_txn({16'h0050, 3'h2}, 16'h0050);
        @(posedge clk); #1;
        rsp_tready = 1'b0;
        checks++;
        if (rsp_tlast !== 1'b1 || defer_cnt !== 5'd4) begin
            failures++;
            $display("FAIL rst_setup got tlast=%0b cnt=%0d, expected 1/4", rsp_tlast, defer_cnt);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (rsp_tvalid !== 1'b0 || defer_cnt !== 5'd0 || rsp_tlast !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got v=%0b cnt=%0d l=%0b, expected 0/0/0", rsp_tvalid, defer_cnt, rsp_tlast);
        end
        @(negedge clk);
        reset = 1'b0;
        dev_opmode = 1'b1; rsp_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL rst_quiet got tvalid=%0b, expected 0", rsp_tvalid);
            end
        end
        @(posedge clk); #1;
        expect_txn({16'h0060, 3'h4}, 16'h0060);
        drive_txn({16'h0060, 3'h4}, 16'h0060);
        wait_idle(20);
    endtask

    initial begin
        test_reset();
        test_direct();
        test_backpressure();
        test_defer_drain();
        test_full();
        test_drain_priority();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover got %0d pending beats, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dev_rsp_serializer.md
# dev_rsp_serializer

Device-side transmitter for the request stream path. Accepts single-cycle device transactions (19-bit address, 16-bit data) on a valid-ready interface and serializes each one into a two-beat AXI Stream: address beat, then data beat. Transactions with a deferred ID are parked in a FIFO while the device is not in operational mode. They are drained ahead of new traffic once the mode is asserted. The block sits between the device and the stream fabric, opposite the request buffering block.

## Interface
- DEPTH, 16: deferred-transaction FIFO depth; power of two, at least 2
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- dev_valid_i  in  1  device transaction valid
- dev_addr_i  in  19  {tdata[15:0], tid[2:0]} of the address beat
- dev_data_i  in  16  payload of the data beat
- dev_ready_o  out  1  transaction accepted when high with dev_valid_i
- dev_opmode_i  in  1  1 = operational (drain allowed), 0 = defer DEFER_TID traffic
- rsp_tvalid_o  out  1  stream beat valid
- rsp_tid_o  out  3  stream ID, always dev_addr[2:0] of the transaction
- rsp_tdata_o  out  16  beat payload
- rsp_tlast_o  out  1  high on the data (second) beat only
- rsp_tready_i  in  1  downstream ready
- defer_cnt_o  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- The `defer` condition is dev_valid_i & (dev_addr_i[2:0] == DEFER_TID) & ~dev_opmode_i.
- The `drain` condition is (cs == IDLE) & ~fifo_empty & dev_opmode_i.
- dev_ready_o = defer ? ~fifo_full : ((cs == IDLE) & ~drain).
  - Ready depends on valid and addr. This is legal; valid must never depend on ready.
- Push: defer & ~fifo_full writes {dev_addr_i, dev_data_i} (35 bits) into the FIFO. The FSM does not move.
- Pop: on drain, the FIFO head is loaded into addr_q/data_q and the FSM goes to ADDR. Any dev_valid_i in that cycle is stalled.
- Direct accept: dev_valid_i & dev_ready_o & ~defer loads addr_q/data_q and the FSM goes to ADDR.
- Push and pop never occur in the same cycle, because defer and drain need opposite dev_opmode_i. No simultaneous-access handling is required.
- FSM states:
  - IDLE: rsp_tvalid_o = 0.
  - ADDR: tvalid = 1, tdata = addr_q[18:3], tid = addr_q[2:0], tlast = 0. On rsp_tready_i, go to DATA.
  - DATA: tvalid = 1, tdata = data_q, tid = addr_q[2:0], tlast = 1. On rsp_tready_i, go to IDLE.
- Ordering:
  - Deferred traffic stays FIFO-ordered.
  - Non-deferred traffic may overtake deferred traffic while dev_opmode_i = 0.
- While dev_opmode_i = 1, the FIFO must be empty before a new direct transaction is accepted.
- If dev_opmode_i falls mid-drain, the current two-beat transfer completes. Remaining entries wait.
- defer_cnt_o increments on push and decrements on pop. It saturates naturally at DEPTH because pushes are blocked when full.

## Timing
- Reset values:
  - rsp_tvalid_o = 0, rsp_tlast_o = 0, rsp_tid_o = 0, rsp_tdata_o = 0.
  - defer_cnt_o = 0, FIFO empty, cs = IDLE.
  - dev_ready_o = 1 combinationally unless defer & full; full is impossible after reset.
- Reset mid-transfer drops the in-flight transaction and all FIFO contents. No partial beat is emitted after reset deasserts.
- Latency:
  - Direct accept at cycle N gives the address beat valid at N+1.
  - With tready tied high, the data beat is at N+2 and IDLE at N+3.
  - Peak throughput is one transaction per 3 cycles.
- Drain: FIFO nonempty with opmode high at cycle N (IDLE) gives the address beat at N+1.
- Stream outputs are registered (cs, addr_q, data_q). They must hold stable while tvalid & ~tready.
- Full boundary: with defer_cnt_o == DEPTH and defer high, dev_ready_o = 0, and the upstream holds.

## Structure
- Package dev_rsp_pkg holds:
  - DEFER_TID = 3'h5
  - state_t enum {IDLE, ADDR, DATA}, 2 bits
  - localparams ADDR_W = 19, DATA_W = 16, ENTRY_W = 35
- Sub-module: instantiate the existing qs_fifo with DEPTH and DATA_W = ENTRY_W. Do not reimplement the FIFO.
- defer_cnt_o is a local counter in this block.

## Test plan
- Direct transfer:
  - Stimulus: opmode = 1, addr = 19'h1_2343 (tid 3), data = 16'hBEEF, tready = 1.
  - Response: beat tdata = 16'h2468/tid 3/tlast 0 at N+1, then 16'hBEEF/tid 3/tlast 1 at N+2.
- Backpressure:
  - Stimulus: same transaction, tready low for 4 cycles on each beat.
  - Response: tvalid, tdata, tid and tlast stay stable; dev_ready_o = 0 until IDLE.
- Defer then drain:
  - Stimulus: opmode = 0, three tid-5 transactions with data 1, 2, 3.
  - Response while opmode = 0: defer_cnt_o = 3 and no beats.
  - Response after opmode rises: three two-beat transfers with data beats 1, 2, 3 in order, then defer_cnt_o = 0.
- Full FIFO:
  - Stimulus: opmode = 0, 17 tid-5 transactions.
  - Response: the 17th sees dev_ready_o = 0 and defer_cnt_o = 16.
  - Stimulus: a tid-2 transaction in the same state.
  - Response: accepted and transmitted immediately.
- Drain priority:
  - Stimulus: FIFO holds 2 entries, opmode rises while a direct tid-1 transaction is presented.
  - Response: both FIFO entries are sent first, then the tid-1 transaction is accepted.
- Reset mid-transfer:
  - Stimulus: assert reset during the DATA beat with 4 entries deferred.
  - Response: tvalid = 0 and defer_cnt_o = 0 immediately; nothing is emitted after deassert until a new input arrives.
